// File: rtl/bus_slave85.sv
// -----------------------------------------------------------------------------
// bus_slave85
// Memory/IO responder on a multiplexed 8085-style bus. It latches the address
// from the AD bus while ale is high and decodes a 2**MEMBITS byte RAM window.
// It inserts WAITCNT wait states through ready, then drives a synchronous RAM
// back-end, or returns RAM read data on the AD bus.
//
// Optional feature macro: BUSSLV_IOPORT_EN
//   When defined, IO cycles (iom latched high, addr[7:3]==0) reach an 8x8 port
//   file. Port accesses have zero wait states and never strobe the RAM. The port
//   file is visible on port_q. When undefined, IO cycles are treated as
//   unselected and port_q does not exist.
//
// Ports
//   clk        in   system clock, posedge
//   rst_       in   asynchronous reset, active low
//   ale        in   address latch enable
//   ad_d       in   AD bus input (address low byte / write data)
//   a_hi       in   upper address byte
//   iom        in   1 = IO cycle, 0 = memory cycle
//   rd_, wr_   in   read / write strobes, active low
//   ad_q       out  read data toward the AD bus
//   ad_oe      out  AD bus drive enable
//   ready      out  0 = insert wait state
//   ram_addr   out  RAM address (offset inside the window)
//   ram_wdata  out  RAM write data
//   ram_we     out  RAM write strobe, one clk
//   ram_re     out  RAM read strobe, one clk; data valid the following clk
//   ram_rdata  in   RAM read data
//   port_q     out  flat view of the port file (BUSSLV_IOPORT_EN only)
// -----------------------------------------------------------------------------
module bus_slave85 #(
  parameter int                  DATASIZE = 8,
  parameter int                  ADDRSIZE = 16,
  parameter int                  MEMBITS  = 12,
  parameter logic [ADDRSIZE-1:0] MEMBASE  = 16'h0000,
  parameter int                  WAITCNT  = 1
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                ale,
  input  logic [DATASIZE-1:0] ad_d,
  input  logic [7:0]          a_hi,
  input  logic                iom,
  input  logic                rd_,
  input  logic                wr_,
  output logic [DATASIZE-1:0] ad_q,
  output logic                ad_oe,
  output logic                ready,
  output logic [MEMBITS-1:0]  ram_addr,
  output logic [DATASIZE-1:0] ram_wdata,
  output logic                ram_we,
  output logic                ram_re,
  input  logic [DATASIZE-1:0] ram_rdata
`ifdef BUSSLV_IOPORT_EN
  ,
  output logic [63:0]         port_q
`endif
);

  localparam logic [3:0] LP_WAIT = 4'(WAITCNT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RACC, S_RDAT, S_WACC, S_HOLD
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDRSIZE-1:0] r_addr;
  logic                r_iom;
  logic                r_rd_q, r_wr_q;
  logic                r_isrd, w_isrd_nxt;
  logic [3:0]          r_count, w_count_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_ad_oe, w_ad_oe_nxt;
  logic                r_ram_we, w_ram_we_nxt;
  logic                r_ram_re, w_ram_re_nxt;
  logic [DATASIZE-1:0] r_ad_q, w_ad_q_nxt;
  logic [DATASIZE-1:0] r_ram_wdata, w_ram_wdata_nxt;
  logic                w_sel_mem, w_io_hit, w_start, w_released;

`ifdef BUSSLV_IOPORT_EN
  logic [7:0] r_port [8];
  logic       r_io, w_io_nxt, w_port_we;
  assign w_io_hit = r_iom & (r_addr[7:3] == 5'd0);
`else
  assign w_io_hit = 1'b0;
`endif

  // Only the bits above the window are decoded, so offsets wrap in-window.
  assign w_sel_mem  = ~r_iom & (r_addr[ADDRSIZE-1:MEMBITS] == MEMBASE[ADDRSIZE-1:MEMBITS]);
  // A start is a falling strobe edge seen against the previous clk's sample.
  assign w_start    = (r_state == S_IDLE) & ((~rd_ & r_rd_q) | (~wr_ & r_wr_q));
  assign w_released = r_isrd ? rd_ : wr_;

  assign ram_addr  = r_addr[MEMBITS-1:0];
  assign ad_q      = r_ad_q;
  assign ad_oe     = r_ad_oe;
  assign ready     = r_ready;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign ram_re    = r_ram_re;

  always_comb begin
    w_state_nxt     = r_state;
    w_isrd_nxt      = r_isrd;
    w_count_nxt     = r_count;
    w_ready_nxt     = r_ready;
    w_ad_oe_nxt     = r_ad_oe;
    w_ad_q_nxt      = r_ad_q;
    w_ram_wdata_nxt = r_ram_wdata;
    w_ram_we_nxt    = 1'b0;
    w_ram_re_nxt    = 1'b0;
`ifdef BUSSLV_IOPORT_EN
    w_io_nxt        = r_io;
    w_port_we       = 1'b0;
`endif

    unique case (r_state)
      S_IDLE: begin
        // Both strobes low is a bus error: no start is taken.
        if (w_start && (rd_ ^ wr_) && (w_sel_mem || w_io_hit)) begin
          w_isrd_nxt = ~rd_;
`ifdef BUSSLV_IOPORT_EN
          w_io_nxt   = w_io_hit;
`endif
          if (!w_io_hit && (LP_WAIT != 4'd0)) begin
            w_state_nxt = S_WAIT;
            w_count_nxt = LP_WAIT;
            w_ready_nxt = 1'b0;
          end else begin
            w_state_nxt  = ~rd_ ? S_RACC : S_WACC;
            w_ram_re_nxt = ~rd_ & ~w_io_hit;
          end
        end
      end
      S_WAIT: begin
        // Exit while count is 1 so ready is low for exactly WAITCNT clks.
        if (r_count <= 4'd1) begin
          w_ready_nxt  = 1'b1;
          w_state_nxt  = r_isrd ? S_RACC : S_WACC;
          w_ram_re_nxt = r_isrd;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end
      S_RACC: w_state_nxt = S_RDAT;
      S_RDAT: begin
        w_ad_q_nxt = ram_rdata;
`ifdef BUSSLV_IOPORT_EN
        if (r_io) w_ad_q_nxt = DATASIZE'(r_port[r_addr[2:0]]);
`endif
        w_ad_oe_nxt = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_WACC: begin
`ifdef BUSSLV_IOPORT_EN
        if (r_io) begin
          w_port_we = 1'b1;
        end else begin
          w_ram_we_nxt    = 1'b1;
          w_ram_wdata_nxt = ad_d;
        end
`else
        w_ram_we_nxt    = 1'b1;
        w_ram_wdata_nxt = ad_d;
`endif
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (rd_ && wr_) begin
          w_ad_oe_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A new address phase, or losing the strobe before the data phase ends,
    // abandons the cycle without touching RAM or ports.
    if ((r_state != S_IDLE) && (ale || (w_released && (r_state != S_HOLD)))) begin
      w_state_nxt  = S_IDLE;
      w_ready_nxt  = 1'b1;
      w_ad_oe_nxt  = 1'b0;
      w_ram_we_nxt = 1'b0;
      w_ram_re_nxt = 1'b0;
`ifdef BUSSLV_IOPORT_EN
      w_port_we    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_iom       <= 1'b0;
      r_rd_q      <= 1'b1;
      r_wr_q      <= 1'b1;
      r_isrd      <= 1'b0;
      r_count     <= 4'd0;
      r_ready     <= 1'b1;
      r_ad_oe     <= 1'b0;
      r_ad_q      <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
    end else begin
      r_rd_q <= rd_;
      r_wr_q <= wr_;
      if (ale) begin
        r_addr <= {a_hi, ad_d};
        r_iom  <= iom;
      end
      r_state     <= w_state_nxt;
      r_isrd      <= w_isrd_nxt;
      r_count     <= w_count_nxt;
      r_ready     <= w_ready_nxt;
      r_ad_oe     <= w_ad_oe_nxt;
      r_ad_q      <= w_ad_q_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_re    <= w_ram_re_nxt;
    end
  end

`ifdef BUSSLV_IOPORT_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_io <= 1'b0;
      for (int i = 0; i < 8; i++) r_port[i] <= 8'd0;
    end else begin
      r_io <= w_io_nxt;
      if (w_port_we) r_port[r_addr[2:0]] <= ad_d[7:0];
    end
  end

  always_comb begin
    port_q = '0;
    for (int i = 0; i < 8; i++) port_q[i*8 +: 8] = r_port[i];
  end
`endif

endmodule

// File: tb/tb_bus_slave85.sv
// -----------------------------------------------------------------------------
// tb_bus_slave85
// Directed bench for bus_slave85. Two instances share the bus pins: u1 with
// WAITCNT=1 and u3 with WAITCNT=3. Each instance has its own synchronous RAM
// model. The IO port section is built only when BUSSLV_IOPORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_bus_slave85;

  logic       clk = 1'b0;
  logic       rst_, ale, iom, rd_, wr_;
  logic [7:0] ad_d, a_hi;

  logic [7:0]  ad_q1, ram_wdata1, ram_rdata1, ad_q3, ram_wdata3, ram_rdata3;
  logic        ad_oe1, ready1, ram_we1, ram_re1, ad_oe3, ready3, ram_we3, ram_re3;
  logic [11:0] ram_addr1, ram_addr3;
`ifdef BUSSLV_IOPORT_EN
  logic [63:0] port_q1, port_q3;
`endif

  always #5 clk = ~clk;

  bus_slave85 #(.WAITCNT(1)) u1 (
    .clk(clk), .rst_(rst_), .ale(ale), .ad_d(ad_d), .a_hi(a_hi), .iom(iom),
    .rd_(rd_), .wr_(wr_), .ad_q(ad_q1), .ad_oe(ad_oe1), .ready(ready1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1),
    .ram_re(ram_re1), .ram_rdata(ram_rdata1)
`ifdef BUSSLV_IOPORT_EN
    , .port_q(port_q1)
`endif
  );

  bus_slave85 #(.WAITCNT(3)) u3 (
    .clk(clk), .rst_(rst_), .ale(ale), .ad_d(ad_d), .a_hi(a_hi), .iom(iom),
    .rd_(rd_), .wr_(wr_), .ad_q(ad_q3), .ad_oe(ad_oe3), .ready(ready3),
    .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_we(ram_we3),
    .ram_re(ram_re3), .ram_rdata(ram_rdata3)
`ifdef BUSSLV_IOPORT_EN
    , .port_q(port_q3)
`endif
  );

  // Synchronous RAM models plus event counters, sampled on the active edge.
  logic [7:0]  mem1 [0:4095];
  logic [7:0]  mem3 [0:4095];
  logic [11:0] last_waddr1, last_waddr3;
  logic [7:0]  last_wdata1, last_wdata3;
  int we1 = 0, re1 = 0, rl1 = 0, oe1 = 0;
  int we3 = 0, re3 = 0, rl3 = 0, oe3 = 0;

  always @(posedge clk) begin
    if (ram_we1) begin
      mem1[ram_addr1] <= ram_wdata1;
      last_waddr1 <= ram_addr1;
      last_wdata1 <= ram_wdata1;
      we1 <= we1 + 1;
    end
    if (ram_re1) begin
      ram_rdata1 <= mem1[ram_addr1];
      re1 <= re1 + 1;
    end
    if (!ready1) rl1 <= rl1 + 1;
    if (ad_oe1)  oe1 <= oe1 + 1;
    if (ram_we3) begin
      mem3[ram_addr3] <= ram_wdata3;
      last_waddr3 <= ram_addr3;
      last_wdata3 <= ram_wdata3;
      we3 <= we3 + 1;
    end
    if (ram_re3) begin
      ram_rdata3 <= mem3[ram_addr3];
      re3 <= re3 + 1;
    end
    if (!ready3) rl3 <= rl3 + 1;
    if (ad_oe3)  oe3 <= oe3 + 1;
  end

  int checks = 0;
  int errors = 0;
  int s_we1, s_re1, s_rl1, s_oe1, s_we3, s_re3, s_rl3, s_oe3;
  logic [7:0] seen1, seen3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_we1 = we1; s_re1 = re1; s_rl1 = rl1; s_oe1 = oe1;
    s_we3 = we3; s_re3 = re3; s_rl3 = rl3; s_oe3 = oe3;
  endtask

  // Ends on the negedge where ale drops, ready for the strobe to be driven.
  task automatic addr_phase(input logic [15:0] a);
    @(negedge clk);
    ale = 1'b1; a_hi = a[15:8]; ad_d = a[7:0];
    @(negedge clk);
    ale = 1'b0;
  endtask

  task automatic wcycle(input logic [15:0] a, input logic [7:0] d, input int n);
    addr_phase(a);
    wr_ = 1'b0; ad_d = d;
    repeat (n) @(negedge clk);
    wr_ = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic rcycle(input logic [15:0] a, input int n);
    addr_phase(a);
    rd_ = 1'b0;
    seen1 = 8'h00; seen3 = 8'h00;
    repeat (n) begin
      @(negedge clk);
      if (ad_oe1) seen1 = ad_q1;
      if (ad_oe3) seen3 = ad_q3;
    end
    rd_ = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_ = 1'b0; ale = 1'b0; iom = 1'b0; rd_ = 1'b1; wr_ = 1'b1;
    ad_d = 8'h00; a_hi = 8'h00;
    repeat (2) @(negedge clk);

    chk("rst_ready",     ready1,     1'b1);
    chk("rst_ad_oe",     ad_oe1,     1'b0);
    chk("rst_ad_q",      ad_q1,      8'h00);
    chk("rst_ram_we",    ram_we1,    1'b0);
    chk("rst_ram_re",    ram_re1,    1'b0);
    chk("rst_ram_addr",  ram_addr1,  12'h000);
    chk("rst_ram_wdata", ram_wdata1, 8'h00);
    chk("rst_ready3",    ready3,     1'b1);
    rst_ = 1'b1;
    @(negedge clk);

    // Write 0xA5 to 0x0123 so both RAM models hold it for the read.
    snap();
    wcycle(16'h0123, 8'hA5, 6);
    chk("w123_we1",    we1 - s_we1, 1);
    chk("w123_addr1",  last_waddr1, 12'h123);
    chk("w123_data1",  last_wdata1, 8'hA5);
    chk("w123_we3",    we3 - s_we3, 1);
    chk("w123_rdylo1", rl1 - s_rl1, 1);
    chk("w123_rdylo3", rl3 - s_rl3, 3);

    // Cycle-accurate read on the WAITCNT=1 instance.
    snap();
    addr_phase(16'h0123);
    rd_ = 1'b0;
    @(negedge clk);
    chk("rd_ready_lo1", ready1, 1'b0);
    chk("rd_ready_lo3", ready3, 1'b0);
    @(negedge clk);
    chk("rd_ready_hi1", ready1, 1'b1);
    chk("rd_re_pulse1", ram_re1, 1'b1);
    chk("rd_oe_early1", ad_oe1, 1'b0);
    @(negedge clk);
    chk("rd_re_end1",   ram_re1, 1'b0);
    chk("rd_oe_wait1",  ad_oe1, 1'b0);
    chk("rd_ready_lo3b", ready3, 1'b0);
    @(negedge clk);
    chk("rd_oe1", ad_oe1, 1'b1);
    chk("rd_q1",  ad_q1, 8'hA5);
    rd_ = 1'b1;
    @(negedge clk);
    chk("rd_oe_off1", ad_oe1, 1'b0);
    @(negedge clk);
    chk("rd_re_cnt1",  re1 - s_re1, 1);
    chk("rd_rdylo1",   rl1 - s_rl1, 1);
    chk("rd_rdylo3",   rl3 - s_rl3, 3);
    chk("rd_we_none1", we1 - s_we1, 0);

    // Write to the top byte of the window.
    snap();
    wcycle(16'h0FFF, 8'h3C, 6);
    chk("wfff_we1",   we1 - s_we1, 1);
    chk("wfff_addr1", last_waddr1, 12'hFFF);
    chk("wfff_data1", last_wdata1, 8'h3C);
    chk("wfff_we3",   we3 - s_we3, 1);
    chk("wfff_addr3", last_waddr3, 12'hFFF);
    chk("wfff_data3", last_wdata3, 8'h3C);

    rcycle(16'h0FFF, 7);
    chk("rfff_q1", seen1, 8'h3C);
    chk("rfff_q3", seen3, 8'h3C);
    chk("rfff_oe_off3", ad_oe3, 1'b0);

    // Just above the window: no response at all.
    snap();
    rcycle(16'h1123, 6);
    chk("dec_re1",   re1 - s_re1, 0);
    chk("dec_re3",   re3 - s_re3, 0);
    chk("dec_oe1",   oe1 - s_oe1, 0);
    chk("dec_rdyl1", rl1 - s_rl1, 0);
    chk("dec_rdyl3", rl3 - s_rl3, 0);

    // Write strobe released one clk into the wait states.
    snap();
    addr_phase(16'h0200);
    wr_ = 1'b0; ad_d = 8'h55;
    @(negedge clk);
    chk("ab_ready_lo3", ready3, 1'b0);
    wr_ = 1'b1;
    @(negedge clk);
    chk("ab_ready_hi3", ready3, 1'b1);
    chk("ab_ready_hi1", ready1, 1'b1);
    repeat (5) @(negedge clk);
    chk("ab_we3", we3 - s_we3, 0);
    chk("ab_we1", we1 - s_we1, 0);
    chk("ab_oe3", oe3 - s_oe3, 0);

    // Both strobes low together is ignored.
    snap();
    addr_phase(16'h0050);
    rd_ = 1'b0; wr_ = 1'b0;
    repeat (5) @(negedge clk);
    rd_ = 1'b1; wr_ = 1'b1;
    repeat (2) @(negedge clk);
    chk("both_we1",   we1 - s_we1, 0);
    chk("both_re1",   re1 - s_re1, 0);
    chk("both_we3",   we3 - s_we3, 0);
    chk("both_re3",   re3 - s_re3, 0);
    chk("both_rdyl1", rl1 - s_rl1, 0);
    chk("both_rdyl3", rl3 - s_rl3, 0);

    // Asynchronous reset in the middle of the wait states.
    snap();
    addr_phase(16'h0123);
    rd_ = 1'b0;
    @(negedge clk);
    chk("arst_pre_ready3", ready3, 1'b0);
    #2 rst_ = 1'b0;
    #1;
    chk("arst_ready3",  ready3,  1'b1);
    chk("arst_ready1",  ready1,  1'b1);
    chk("arst_ad_oe3",  ad_oe3,  1'b0);
    chk("arst_ram_we3", ram_we3, 1'b0);
    rd_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_idle_ready3", ready3, 1'b1);
    chk("arst_idle_oe3",    ad_oe3, 1'b0);
    chk("arst_idle_re1",    re1 - s_re1, 0);
    chk("arst_idle_re3",    re3 - s_re3, 0);

    rcycle(16'h0123, 7);
    chk("post_rst_q1", seen1, 8'hA5);
    chk("post_rst_q3", seen3, 8'hA5);

`ifdef BUSSLV_IOPORT_EN
    // OUT 0x05 <- 0x7E, then IN 0x05.
    snap();
    iom = 1'b1;
    addr_phase(16'h0005);
    iom = 1'b0;
    wr_ = 1'b0; ad_d = 8'h7E;
    repeat (4) @(negedge clk);
    wr_ = 1'b1;
    repeat (2) @(negedge clk);
    chk("io_port1",  port_q1[47:40], 8'h7E);
    chk("io_port3",  port_q3[47:40], 8'h7E);
    chk("io_other1", port_q1[39:32], 8'h00);
    chk("io_we1",    we1 - s_we1, 0);
    chk("io_rdyl3",  rl3 - s_rl3, 0);
    iom = 1'b1;
    rcycle(16'h0005, 5);
    iom = 1'b0;
    chk("io_in_q1", seen1, 8'h7E);
    chk("io_in_q3", seen3, 8'h7E);
    chk("io_re1",   re1 - s_re1, 0);
    chk("io_re3",   re3 - s_re3, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
